// File: rtl/lut_net_class_decoder.sv
// Scores the per-class vote bits of a LUT classification network, picks the winning
// class and keeps running accuracy statistics for the labelled stream.
module lut_net_class_decoder #(
    parameter int USER_WIDTH  = 8,
    parameter int CLASS_NUM   = 10,
    parameter int CHANNEL_NUM = 7,
    parameter int COUNT_WIDTH = 32,
    parameter int SCORE_W     = $clog2(CHANNEL_NUM + 1),
    parameter int CLASS_W     = $clog2(CLASS_NUM + 1)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             cke,
    input  logic [USER_WIDTH-1:0]            in_user,
    input  logic                             in_last,
    input  logic [CLASS_NUM*CHANNEL_NUM-1:0] in_data,
    input  logic                             in_valid,
    output logic [USER_WIDTH-1:0]            out_user,
    output logic                             out_last,
    output logic [CLASS_W-1:0]               out_class,
    output logic [SCORE_W-1:0]               out_score,
    output logic                             out_match,
    output logic                             out_valid,
    input  logic                             stat_clear,
    output logic [COUNT_WIDTH-1:0]           stat_total,
    output logic [COUNT_WIDTH-1:0]           stat_ok,
    output logic                             stat_done
);

    localparam int CMP_W = (USER_WIDTH > CLASS_W) ? USER_WIDTH : CLASS_W;

    logic [SCORE_W-1:0]     popScore_d [CLASS_NUM];
    logic [SCORE_W-1:0]     s1Score_q  [CLASS_NUM];
    logic [USER_WIDTH-1:0]  s1User_q;
    logic                   s1Last_q;
    logic                   s1Valid_q;

    logic [CLASS_W-1:0]     bestClass_d;
    logic [SCORE_W-1:0]     bestScore_d;
    logic                   match_d;

    logic [USER_WIDTH-1:0]  outUser_q;
    logic                   outLast_q;
    logic [CLASS_W-1:0]     outClass_q;
    logic [SCORE_W-1:0]     outScore_q;
    logic                   outMatch_q;
    logic                   outValid_q;

    logic [COUNT_WIDTH-1:0] statTotal_q, statTotal_d;
    logic [COUNT_WIDTH-1:0] statOk_q, statOk_d;
    logic                   statDone_q, statDone_d;

    // Channels of one class are interleaved CLASS_NUM bits apart in the beat.
    always_comb begin
        for (int i = 0; i < CLASS_NUM; i++) begin
            popScore_d[i] = '0;
            for (int j = 0; j < CHANNEL_NUM; j++) begin
                popScore_d[i] = popScore_d[i] + SCORE_W'(in_data[j*CLASS_NUM + i]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1Valid_q <= 1'b0;
            s1User_q  <= '0;
            s1Last_q  <= 1'b0;
            for (int i = 0; i < CLASS_NUM; i++) begin
                s1Score_q[i] <= '0;
            end
        end else if (cke) begin
            s1Valid_q <= in_valid;
            if (in_valid) begin
                s1User_q <= in_user;
                s1Last_q <= in_last;
                for (int i = 0; i < CLASS_NUM; i++) begin
                    s1Score_q[i] <= popScore_d[i];
                end
            end
        end
    end

    // Strict greater-than keeps the lowest index on ties; starting from score 0
    // means a beat with no votes at all falls through to the CLASS_NUM marker.
    always_comb begin
        bestClass_d = CLASS_W'(CLASS_NUM);
        bestScore_d = '0;
        for (int i = 0; i < CLASS_NUM; i++) begin
            if (s1Score_q[i] > bestScore_d) begin
                bestClass_d = CLASS_W'(i);
                bestScore_d = s1Score_q[i];
            end
        end
        match_d = (bestScore_d != '0) && (CMP_W'(bestClass_d) == CMP_W'(s1User_q));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            outValid_q <= 1'b0;
            outUser_q  <= '0;
            outLast_q  <= 1'b0;
            outClass_q <= '0;
            outScore_q <= '0;
            outMatch_q <= 1'b0;
        end else if (cke) begin
            outValid_q <= s1Valid_q;
            if (s1Valid_q) begin
                outUser_q  <= s1User_q;
                outLast_q  <= s1Last_q;
                outClass_q <= bestClass_d;
                outScore_q <= bestScore_d;
                outMatch_q <= match_d;
            end
        end
    end

    // A clear on the same cycle as a result beat discards that beat entirely.
    always_comb begin
        statTotal_d = statTotal_q;
        statOk_d    = statOk_q;
        statDone_d  = statDone_q;
        if (stat_clear) begin
            statTotal_d = '0;
            statOk_d    = '0;
            statDone_d  = 1'b0;
        end else if (outValid_q) begin
            if (statTotal_q != '1) begin
                statTotal_d = statTotal_q + COUNT_WIDTH'(1);
            end
            if (outMatch_q && (statOk_q != '1)) begin
                statOk_d = statOk_q + COUNT_WIDTH'(1);
            end
            if (outLast_q) begin
                statDone_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            statTotal_q <= '0;
            statOk_q    <= '0;
            statDone_q  <= 1'b0;
        end else if (cke) begin
            statTotal_q <= statTotal_d;
            statOk_q    <= statOk_d;
            statDone_q  <= statDone_d;
        end
    end

    assign out_user   = outUser_q;
    assign out_last   = outLast_q;
    assign out_class  = outClass_q;
    assign out_score  = outScore_q;
    assign out_match  = outMatch_q;
    assign out_valid  = outValid_q;
    assign stat_total = statTotal_q;
    assign stat_ok    = statOk_q;
    assign stat_done  = statDone_q;

endmodule

// File: tb/tb_lut_net_class_decoder.sv
// Directed bench for lut_net_class_decoder; a second narrow-counter instance
// exercises statistics saturation.
module tb_lut_net_class_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        cke;
    logic [7:0]  in_user;
    logic        in_last;
    logic [69:0] in_data;
    logic        in_valid;
    logic        stat_clear;

    logic [7:0]  out_user;
    logic        out_last;
    logic [3:0]  out_class;
    logic [2:0]  out_score;
    logic        out_match;
    logic        out_valid;
    logic [31:0] stat_total;
    logic [31:0] stat_ok;
    logic        stat_done;

    logic [7:0]  satUser;
    logic        satLast;
    logic [3:0]  satClass;
    logic [2:0]  satScore;
    logic        satMatch;
    logic        satValid;
    logic [2:0]  satTotal;
    logic [2:0]  satOk;
    logic        satDone;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    lut_net_class_decoder dut (
        .clk(clk), .reset(reset), .cke(cke),
        .in_user(in_user), .in_last(in_last), .in_data(in_data), .in_valid(in_valid),
        .out_user(out_user), .out_last(out_last), .out_class(out_class),
        .out_score(out_score), .out_match(out_match), .out_valid(out_valid),
        .stat_clear(stat_clear), .stat_total(stat_total), .stat_ok(stat_ok),
        .stat_done(stat_done)
    );

    lut_net_class_decoder #(.COUNT_WIDTH(3)) dutSat (
        .clk(clk), .reset(reset), .cke(cke),
        .in_user(in_user), .in_last(in_last), .in_data(in_data), .in_valid(in_valid),
        .out_user(satUser), .out_last(satLast), .out_class(satClass),
        .out_score(satScore), .out_match(satMatch), .out_valid(satValid),
        .stat_clear(stat_clear), .stat_total(satTotal), .stat_ok(satOk),
        .stat_done(satDone)
    );

    function automatic logic [69:0] votes(input int cls, input int n);
        logic [69:0] v;
        v = '0;
        for (int j = 0; j < n; j++) begin
            v[j*10 + cls] = 1'b1;
        end
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [69:0] d, input logic [7:0] u, input logic l);
        in_valid = 1'b1;
        in_data  = d;
        in_user  = u;
        in_last  = l;
        tick();
    endtask

    // Idle beats carry X payload, which must never reach the outputs.
    task automatic idleCycle();
        in_valid = 1'b0;
        in_data  = 'x;
        in_user  = 'x;
        in_last  = 1'bx;
        tick();
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        reset = 1'b1; cke = 1'b1; stat_clear = 1'b0;
        in_valid = 1'b0; in_data = '0; in_user = '0; in_last = 1'b0;
        tick();
        tick();
        checkOutput("rst_valid", 32'(out_valid), 0);
        checkOutput("rst_class", 32'(out_class), 0);
        checkOutput("rst_score", 32'(out_score), 0);
        checkOutput("rst_user", 32'(out_user), 0);
        checkOutput("rst_total", stat_total, 0);
        checkOutput("rst_ok", stat_ok, 0);
        checkOutput("rst_done", 32'(stat_done), 0);
        reset = 1'b0;

        $display("[TB] single beat, class 3 full vote");
        applyStimulus(votes(3, 7), 8'd3, 1'b0);
        idleCycle();
        checkOutput("t1_valid", 32'(out_valid), 1);
        checkOutput("t1_class", 32'(out_class), 3);
        checkOutput("t1_score", 32'(out_score), 7);
        checkOutput("t1_match", 32'(out_match), 1);
        checkOutput("t1_user", 32'(out_user), 3);
        idleCycle();
        checkOutput("t1_valid_drop", 32'(out_valid), 0);
        checkOutput("t1_total", stat_total, 1);
        checkOutput("t1_ok", stat_ok, 1);
        checkOutput("t1_done", 32'(stat_done), 0);

        $display("[TB] tie between class 2 and 5");
        applyStimulus(votes(2, 4) | votes(5, 4), 8'd5, 1'b0);
        idleCycle();
        checkOutput("tie_class", 32'(out_class), 2);
        checkOutput("tie_score", 32'(out_score), 4);
        checkOutput("tie_match", 32'(out_match), 0);
        idleCycle();
        checkOutput("tie_total", stat_total, 2);
        checkOutput("tie_ok", stat_ok, 1);

        $display("[TB] no votes");
        applyStimulus('0, 8'd0, 1'b0);
        idleCycle();
        checkOutput("zero_class", 32'(out_class), 10);
        checkOutput("zero_score", 32'(out_score), 0);
        checkOutput("zero_match", 32'(out_match), 0);
        idleCycle();
        checkOutput("zero_total", stat_total, 3);

        $display("[TB] no votes with label equal to CLASS_NUM");
        applyStimulus('0, 8'd10, 1'b0);
        idleCycle();
        checkOutput("zero10_class", 32'(out_class), 10);
        checkOutput("zero10_match", 32'(out_match), 0);
        idleCycle();
        checkOutput("zero10_total", stat_total, 4);
        checkOutput("zero10_ok", stat_ok, 1);

        $display("[TB] last beat with clock-enable stalls");
        applyStimulus(votes(7, 2) | votes(1, 1), 8'd7, 1'b1);
        cke = 1'b0;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(votes(0, 7), 8'd0, 1'b0);
        end
        checkOutput("stall1_valid", 32'(out_valid), 0);
        cke = 1'b1;
        idleCycle();
        checkOutput("stall_valid", 32'(out_valid), 1);
        checkOutput("stall_class", 32'(out_class), 7);
        checkOutput("stall_score", 32'(out_score), 2);
        checkOutput("stall_match", 32'(out_match), 1);
        checkOutput("stall_last", 32'(out_last), 1);
        cke = 1'b0;
        idleCycle();
        idleCycle();
        checkOutput("stall2_valid", 32'(out_valid), 1);
        checkOutput("stall2_total", stat_total, 4);
        checkOutput("stall2_done", 32'(stat_done), 0);
        cke = 1'b1;
        idleCycle();
        checkOutput("last_total", stat_total, 5);
        checkOutput("last_ok", stat_ok, 2);
        checkOutput("last_done", 32'(stat_done), 1);
        checkOutput("hold_class", 32'(out_class), 7);

        $display("[TB] beats after done keep counting");
        applyStimulus(votes(0, 1), 8'd0, 1'b0);
        idleCycle();
        checkOutput("post_class", 32'(out_class), 0);
        checkOutput("post_score", 32'(out_score), 1);
        idleCycle();
        checkOutput("post_total", stat_total, 6);
        checkOutput("post_ok", stat_ok, 3);
        checkOutput("post_done", 32'(stat_done), 1);

        $display("[TB] clear coincident with a result beat");
        applyStimulus(votes(4, 3), 8'd4, 1'b0);
        idleCycle();
        stat_clear = 1'b1;
        idleCycle();
        stat_clear = 1'b0;
        checkOutput("clr_total", stat_total, 0);
        checkOutput("clr_ok", stat_ok, 0);
        checkOutput("clr_done", 32'(stat_done), 0);
        applyStimulus(votes(9, 6), 8'd9, 1'b0);
        applyStimulus(votes(6, 5), 8'd0, 1'b0);
        checkOutput("b2b_a_class", 32'(out_class), 9);
        checkOutput("b2b_a_score", 32'(out_score), 6);
        idleCycle();
        checkOutput("b2b_b_valid", 32'(out_valid), 1);
        checkOutput("b2b_b_class", 32'(out_class), 6);
        checkOutput("b2b_b_match", 32'(out_match), 0);
        checkOutput("b2b_total1", stat_total, 1);
        idleCycle();
        checkOutput("b2b_total2", stat_total, 2);
        checkOutput("b2b_ok", stat_ok, 1);

        $display("[TB] reset with beats in flight");
        applyStimulus(votes(8, 4), 8'd8, 1'b0);
        reset = 1'b1;
        applyStimulus(votes(5, 5), 8'd5, 1'b0);
        reset = 1'b0;
        checkOutput("mrst_total", stat_total, 0);
        checkOutput("mrst_ok", stat_ok, 0);
        idleCycle();
        checkOutput("mrst_valid", 32'(out_valid), 0);
        idleCycle();
        checkOutput("mrst_valid2", 32'(out_valid), 0);
        checkOutput("mrst_total2", stat_total, 0);
        applyStimulus(votes(1, 3), 8'd1, 1'b0);
        idleCycle();
        checkOutput("new_valid", 32'(out_valid), 1);
        checkOutput("new_class", 32'(out_class), 1);
        checkOutput("new_score", 32'(out_score), 3);
        idleCycle();
        checkOutput("new_total", stat_total, 1);
        checkOutput("sat_total1", 32'(satTotal), 1);

        $display("[TB] counter saturation on narrow instance");
        for (int k = 0; k < 9; k++) begin
            applyStimulus(votes(k, 1 + (k % 7)), 8'(k), 1'b0);
        end
        idleCycle();
        idleCycle();
        checkOutput("run_total", stat_total, 10);
        checkOutput("run_ok", stat_ok, 10);
        checkOutput("run_done", 32'(stat_done), 0);
        checkOutput("sat_total", 32'(satTotal), 7);
        checkOutput("sat_ok", 32'(satOk), 7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
